// File: rtl/rgb_breath_pwm.sv
// Multi-channel PWM LED driver: per-channel off / static / breathe / blink with a shared
// triangle envelope. Define RGB_PWM_GAMMA_EN to square the duty for a perceptual curve.
module rgb_breath_pwm #(
    parameter int              CH        = 3,
    parameter int              PWM_W     = 8,
    parameter int              DIV_W     = 16,
    parameter logic [CH-1:0]   PHASE_INV = 3'b010
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic [2*CH-1:0]       mode,
    input  logic [CH*PWM_W-1:0]   duty_in,
    input  logic [DIV_W-1:0]      step_div,
    output logic [CH-1:0]         led,
    output logic                  period_start
);

    logic [PWM_W-1:0] cnt_reg;
    logic [DIV_W-1:0] pcnt_reg;
    logic [PWM_W-1:0] env_reg;
    logic [PWM_W-1:0] env_next;
    logic             dir_reg;
    logic             dir_next;
    logic [CH-1:0]    led_reg;
    logic [CH-1:0]    led_next;
    logic             period_start_reg;
    logic             cnt_max;
    logic             env_step;

    assign cnt_max  = (cnt_reg == '1);
    assign env_step = (pcnt_reg == step_div);

    // Triangle envelope: each extreme is held for one step by reversing straight off it.
    always_comb begin
        env_next = env_reg;
        dir_next = dir_reg;
        if (dir_reg) begin
            if (env_reg == '1) begin
                env_next = env_reg - PWM_W'(1);
                dir_next = 1'b0;
            end else begin
                env_next = env_reg + PWM_W'(1);
            end
        end else begin
            if (env_reg == '0) begin
                env_next = env_reg + PWM_W'(1);
                dir_next = 1'b1;
            end else begin
                env_next = env_reg - PWM_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg          <= '0;
            pcnt_reg         <= '0;
            env_reg          <= '0;
            dir_reg          <= 1'b1;
            led_reg          <= '0;
            period_start_reg <= 1'b0;
        end else if (en) begin
            cnt_reg          <= cnt_reg + PWM_W'(1);
            led_reg          <= led_next;
            period_start_reg <= (cnt_reg == '0);
            if (cnt_max) begin
                if (env_step) begin
                    pcnt_reg <= '0;
                    env_reg  <= env_next;
                    dir_reg  <= dir_next;
                end else begin
                    pcnt_reg <= pcnt_reg + DIV_W'(1);
                end
            end
        end else begin
            led_reg          <= '0;
            period_start_reg <= 1'b0;
        end
    end

    generate
        for (genvar gi = 0; gi < CH; gi++) begin : g_ch
            logic [1:0]       ch_mode;
            logic [PWM_W-1:0] ch_duty;
            logic [PWM_W-1:0] raw_duty;
            logic [PWM_W-1:0] eff_duty;
            logic [PWM_W-1:0] sh_reg;

            assign ch_mode = mode[2*gi +: 2];
            assign ch_duty = duty_in[gi*PWM_W +: PWM_W];

            always_comb begin
                raw_duty = '0;
                case (ch_mode)
                    2'b00: raw_duty = '0;
                    2'b01: raw_duty = ch_duty;
                    2'b10: raw_duty = PHASE_INV[gi] ? ~env_reg : env_reg;
                    2'b11: raw_duty = (dir_reg ^ PHASE_INV[gi]) ? ch_duty : '0;
                    default: raw_duty = '0;
                endcase
            end

`ifdef RGB_PWM_GAMMA_EN
            logic [2*PWM_W-1:0] sq;
            assign sq       = {{PWM_W{1'b0}}, raw_duty} * {{PWM_W{1'b0}}, raw_duty};
            assign eff_duty = PWM_W'(sq >> PWM_W);
`else
            assign eff_duty = raw_duty;
`endif

            // Shadow loads only on the last cycle of a period, so a period never changes mid-way.
            always_ff @(posedge clk) begin
                if (reset) begin
                    sh_reg <= '0;
                end else if (en && cnt_max) begin
                    sh_reg <= eff_duty;
                end
            end

            assign led_next[gi] = (sh_reg > cnt_reg);
        end
    endgenerate

    assign led          = led_reg;
    assign period_start = period_start_reg;

endmodule

// File: tb/tb_rgb_breath_pwm.sv
// Self-checking bench for rgb_breath_pwm (CH=3, PWM_W=4): per-cycle model compare plus
// directed per-period high-count checks.
module tb_rgb_breath_pwm;
    localparam int MAXV = 15;
    localparam int PER  = 16;
    localparam logic [2:0] INV = 3'b010;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b1;
    logic [5:0]  mode = '0;
    logic [11:0] duty_in = '0;
    logic [3:0]  step_div = '0;
    logic [2:0]  led;
    logic        period_start;

    always #5 clk = ~clk;

    rgb_breath_pwm #(
        .CH(3), .PWM_W(4), .DIV_W(4), .PHASE_INV(3'b010)
    ) dut (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .duty_in(duty_in),
        .step_div(step_div), .led(led), .period_start(period_start)
    );

    int   checks = 0;
    int   errors = 0;
    bit   chk_on = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Envelope value and direction after k steps, as closed-form triangle functions.
    function automatic int env_of(input int k);
        int p;
        p = k % (2*MAXV);
        return (p <= MAXV) ? p : 2*MAXV - p;
    endfunction

    function automatic int dir_of(input int k);
        int p;
        if (k == 0) return 1;
        p = k % (2*MAXV);
        return (p >= 1 && p <= MAXV) ? 1 : 0;
    endfunction

    function automatic int gam(input int d);
`ifdef RGB_PWM_GAMMA_EN
        return (d * d) >> 4;
`else
        return d;
`endif
    endfunction

    int m_cnt = 0, m_pcnt = 0, m_k = 0;
    int m_sh [3];
    logic [2:0] exp_led = '0;
    logic       exp_ps = 1'b0;

    function automatic int duty_of(input int c);
        int md, dv, inv, e;
        md  = int'(mode[2*c +: 2]);
        dv  = int'(duty_in[4*c +: 4]);
        inv = int'(INV[c]);
        e   = env_of(m_k);
        case (md)
            1: return gam(dv);
            2: return gam(inv != 0 ? MAXV - e : e);
            3: return ((dir_of(m_k) ^ inv) != 0) ? gam(dv) : 0;
            default: return 0;
        endcase
    endfunction

    // Model: period-level bookkeeping (cycle, period count, envelope step count).
    always @(posedge clk) begin
        if (reset) begin
            m_cnt   <= 0;
            m_pcnt  <= 0;
            m_k     <= 0;
            for (int c = 0; c < 3; c++) m_sh[c] <= 0;
            exp_led <= '0;
            exp_ps  <= 1'b0;
        end else if (en) begin
            for (int c = 0; c < 3; c++) exp_led[c] <= (m_sh[c] > m_cnt);
            exp_ps <= (m_cnt == 0);
            if (m_cnt == MAXV) begin
                for (int c = 0; c < 3; c++) m_sh[c] <= duty_of(c);
                if (m_pcnt == int'(step_div)) begin
                    m_pcnt <= 0;
                    m_k    <= m_k + 1;
                end else begin
                    m_pcnt <= m_pcnt + 1;
                end
            end
            m_cnt <= (m_cnt + 1) % PER;
        end else begin
            exp_led <= '0;
            exp_ps  <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("cyc_led", {29'd0, led}, {29'd0, exp_led});
            chk("cyc_ps", {31'd0, period_start}, {31'd0, exp_ps});
        end
    end

    task automatic wait_ps();
        int t;
        t = 0;
        while (period_start !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) chk("ps_timeout", 32'd0, 32'd1);
    endtask

    // Measure one PWM period from its period_start cycle; optionally change inputs mid-way.
    task automatic meas(input int chg_at, input logic [5:0] nmode, input logic [11:0] nduty,
                        output int h0, output int h1, output int h2, output int pat0);
        wait_ps();
        h0 = 0; h1 = 0; h2 = 0; pat0 = 0;
        for (int i = 0; i < PER; i++) begin
            h0 += int'(led[0]);
            h1 += int'(led[1]);
            h2 += int'(led[2]);
            if (led[0]) pat0 |= (1 << i);
            if (i == chg_at) begin
                mode    = nmode;
                duty_in = nduty;
            end
            @(negedge clk);
        end
        $display("period: ch0=%0d ch1=%0d ch2=%0d mode=%b", h0, h1, h2, mode);
    endtask

    int h0, h1, h2, pat;
    int acc, ps_at;

    initial begin
        reset = 1'b1;
        @(negedge clk);
        chk_on = 1;
        chk("rst_led", {29'd0, led}, 0);
        chk("rst_ps", {31'd0, period_start}, 0);
        repeat (2) @(negedge clk);

        // Static duty 5 on channel 0
        mode    = 6'b000001;
        duty_in = 12'h005;
        reset   = 1'b0;
        @(negedge clk);
        chk("ps_after_reset", {31'd0, period_start}, 1);
        meas(-1, mode, duty_in, h0, h1, h2, pat);
        chk("first_period_zero", h0, 0);
        meas(-1, mode, duty_in, h0, h1, h2, pat);
        chk("static5_count", h0, gam(5));
        chk("static5_pattern", pat, 32'h1F);

        // Duty 5 -> 12 mid-period
        meas(7, 6'b000001, 12'h00C, h0, h1, h2, pat);
        chk("dutychg_cur", h0, gam(5));
        meas(-1, mode, duty_in, h0, h1, h2, pat);
        chk("dutychg_next", h0, gam(12));

        // Mode change on the cnt==max edge is captured by that load
        meas(14, 6'b000000, 12'h00C, h0, h1, h2, pat);
        chk("modeedge_cur", h0, gam(12));
        meas(-1, mode, duty_in, h0, h1, h2, pat);
        chk("modeedge_next", h0, 0);

        // Mid-run reset
        meas(0, 6'b000001, 12'h005, h0, h1, h2, pat);
        meas(-1, mode, duty_in, h0, h1, h2, pat);
        chk("prereset_count", h0, gam(5));
        repeat (3) @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("inreset_led", {29'd0, led}, 0);
            chk("inreset_ps", {31'd0, period_start}, 0);
        end
        reset = 1'b0;
        @(negedge clk);
        chk("ps_after_midreset", {31'd0, period_start}, 1);
        meas(-1, mode, duty_in, h0, h1, h2, pat);
        chk("postreset_first", h0, 0);
        meas(-1, mode, duty_in, h0, h1, h2, pat);
        chk("postreset_second", h0, gam(5));

        // Breathe on ch0 and ch1, step_div=0
        reset = 1'b1; mode = 6'b001010; step_div = 4'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        for (int p = 0; p <= 32; p++) begin
            meas(-1, mode, duty_in, h0, h1, h2, pat);
            chk("breathe_ch0", h0, (p == 0) ? 0 : gam(env_of(p - 1)));
            chk("breathe_ch1", h1, (p == 0) ? 0 : gam(MAXV - env_of(p - 1)));
            if (p == 1)  chk("breathe_p1", h0, 0);
            if (p == 16) chk("breathe_p16", h0, gam(15));
            if (p == 17) chk("breathe_p17", h0, gam(14));
            if (p == 31) chk("breathe_p31", h0, 0);
            if (p == 16) chk("breathe_inv_p16", h1, 0);
        end

        // Blink, duty 15, step_div=1
        reset = 1'b1; mode = 6'b001111; duty_in = 12'h0FF; step_div = 4'd1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        for (int p = 0; p <= 94; p++) begin
            meas(-1, mode, duty_in, h0, h1, h2, pat);
            chk("blink_ch0", h0, (p == 0) ? 0 : ((dir_of((p - 1) / 2) != 0) ? gam(15) : 0));
            chk("blink_ch1", h1, (p == 0) ? 0 : ((dir_of((p - 1) / 2) == 0) ? gam(15) : 0));
            if (p == 32) chk("blink_p32", h0, gam(15));
            if (p == 33) chk("blink_p33", h0, 0);
            if (p == 62) chk("blink_p62", h0, 0);
            if (p == 63) chk("blink_p63", h0, gam(15));
            if (p == 92) chk("blink_p92", h0, gam(15));
            if (p == 93) chk("blink_p93", h0, 0);
            if (p == 93) chk("blink_p93_ch1", h1, gam(15));
        end

        // step_div all ones: one envelope step every 16 periods
        reset = 1'b1; mode = 6'b000010; step_div = 4'hF;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        for (int p = 0; p <= 34; p++) begin
            meas(-1, mode, duty_in, h0, h1, h2, pat);
            chk("slow_ch0", h0, (p == 0) ? 0 : gam(env_of((p - 1) / 16)));
            if (p == 16) chk("slow_p16", h0, gam(0));
            if (p == 33) chk("slow_p33", h0, gam(2));
        end

        // Duty 8 and 15 (gamma curve when enabled)
        meas(0, 6'b010001, 12'hF08, h0, h1, h2, pat);
        meas(-1, mode, duty_in, h0, h1, h2, pat);
`ifdef RGB_PWM_GAMMA_EN
        chk("gamma_d8", h0, 4);
        chk("gamma_d15", h2, 14);
`else
        chk("linear_d8", h0, 8);
        chk("linear_d15", h2, 15);
`endif

        // en low for 20 cycles at cnt==9 (channel 2 static 15)
        repeat (8) @(negedge clk);
        en  = 1'b0;
        acc = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            acc += int'(led[2]) + int'(led[0]) + int'(period_start);
        end
        chk("en_low_quiet", acc, 0);
        en    = 1'b1;
        acc   = 0;
        ps_at = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i <= 7) acc += int'(led[2]);
            if (period_start === 1'b1 && ps_at == 0) ps_at = i;
        end
        chk("resume_ps_delay", ps_at, 8);
`ifdef RGB_PWM_GAMMA_EN
        chk("resume_high_cnt", acc, 5);
`else
        chk("resume_high_cnt", acc, 6);
`endif
        meas(-1, mode, duty_in, h0, h1, h2, pat);
        chk("resume_full_period", h2, gam(15));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

endmodule
